// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with two write ports, same-cycle bypass and a busy scoreboard.
// Reads are combinational; writes, scoreboard updates and reset clear all happen at the clock edge.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]              rd_busy,
    input  logic                           wa_en,
    input  logic [ADDR_WIDTH-1:0]          wa_addr,
    input  logic [DATA_WIDTH-1:0]          wa_data,
    input  logic                           wb_en,
    input  logic [ADDR_WIDTH-1:0]          wb_addr,
    input  logic [DATA_WIDTH-1:0]          wb_data,
    input  logic                           sb_set_en,
    input  logic [ADDR_WIDTH-1:0]          sb_set_addr,
    output logic [2**ADDR_WIDTH-1:0]       busy_vec,
    input  logic [ADDR_WIDTH-1:0]          dbg_addr,
    output logic [DATA_WIDTH-1:0]          dbg_data
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    logic                  wa_ok, wb_ok, set_ok;

    function automatic logic live(input logic [ADDR_WIDTH-1:0] a);
        return !(ZERO_REG != 0 && a == '0);
    endfunction

    assign wa_ok  = wa_en && live(wa_addr);
    assign wb_ok  = wb_en && live(wb_addr);
    assign set_ok = sb_set_en && live(sb_set_addr);

    // Port B is applied after A so it wins a collision; the set comes last so a new producer stays outstanding.
    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        if (wa_ok) begin
            mem_d[wa_addr]  = wa_data;
            busy_d[wa_addr] = 1'b0;
        end
        if (wb_ok) begin
            mem_d[wb_addr]  = wb_data;
            busy_d[wb_addr] = 1'b0;
        end
        if (set_ok) busy_d[sb_set_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_WIDTH-1:0] a;
        logic                  hit_a, hit_b;
        assign a     = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit_a = wa_en && wa_addr == a;
        assign hit_b = wb_en && wb_addr == a;
        assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = (reset || !live(a)) ? '0 :
                                                     hit_b ? wb_data :
                                                     hit_a ? wa_data : mem_q[a];
        assign rd_busy[g] = !reset && busy_q[a] && !hit_a && !hit_b;
    end

    assign busy_vec = busy_q;
    assign dbg_data = reset ? '0 : mem_q[dbg_addr];
endmodule
